// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory wait-state responder.
package data_mem_responder_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_BITS = 32;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  // Responder FSM state encodings
  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_RESP = 2'd2
  } rsp_state_e;

  // Request captured at accept time; later bus changes are ignored
  typedef struct packed {
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_W-1:0]    data;
  } req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus: request from the core, response from the responder.
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic                 ce;
  logic                 we;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_W-1:0]    dataIn;
  logic [DATA_W-1:0]    dataOut;
  logic                 ready;
  logic                 err;
  logic                 busy;

  modport master (
    output ce, we, addr, dataIn,
    input  dataOut, ready, err, busy
  );

  modport slave (
    input  ce, we, addr, dataIn,
    output dataOut, ready, err, busy
  );

endinterface

// File: rtl/data_ram_array.sv
// Word storage: synchronous write, synchronous read, no reset on contents.
module data_ram_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write on we, read the addressed word every cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state responder: accepts one request, waits WAIT_CYCLES, then
// returns a one-cycle ready pulse with read data or an error flag.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_responder_if.slave bus
);

  rsp_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  req_t              req_q;
  logic [DATA_W-1:0] data_out_q;
  logic              ready_q;
  logic              err_q;
  logic              busy_q;

  logic              misaligned_c;
  logic              out_of_range_c;
  logic              req_err_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_dout;

  // Decode the latched request
  assign misaligned_c   = |req_q.addr[1:0];
  assign out_of_range_c = |req_q.addr[ADDR_BITS-1:ADDR_W+2];
  assign req_err_c      = misaligned_c | out_of_range_c;

  // In IDLE look up the incoming address so a zero-wait read has its data
  // by the response edge; afterwards hold the latched index.
  always_comb begin
    ram_addr_c = req_q.addr[ADDR_W+1:2];
    if (state_q == RSP_IDLE) begin
      ram_addr_c = bus.addr[ADDR_W+1:2];
    end
    ram_we_c = (state_q == RSP_RESP) && req_q.we && !req_err_c;
  end

  data_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_c),
    .addr (ram_addr_c),
    .din  (req_q.data),
    .dout (ram_dout)
  );

  // Responder FSM with registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RSP_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      data_out_q <= ZERO_WORD;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        RSP_IDLE: begin
          if (bus.ce) begin
            req_q   <= '{we: bus.we, addr: bus.addr, data: bus.dataIn};
            cnt_q   <= CNT_W'(WAIT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= (WAIT_CYCLES > 0) ? RSP_WAIT : RSP_RESP;
          end
        end
        RSP_WAIT: begin
          if (!bus.ce) begin
            // Initiator withdrew the request: drop it silently
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= RSP_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= RSP_RESP;
            end
          end
        end
        RSP_RESP: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= RSP_IDLE;
          if (req_err_c) begin
            err_q      <= 1'b1;
            data_out_q <= ZERO_WORD;
          end else if (!req_q.we) begin
            data_out_q <= ram_dout;
          end
        end
        default: begin
          state_q <= RSP_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dataOut = data_out_q;
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with two wait cycles, one with none.
module tb_data_mem_responder;

  logic clk;
  logic rst;

  logic [1:0]  ce_v;
  logic [1:0]  we_v;
  logic [31:0] addr_v [2];
  logic [31:0] din_v  [2];
  logic [31:0] dout_v [2];
  logic [1:0]  rdy_v;
  logic [1:0]  err_v;
  logic [1:0]  busy_v;

  int checks;
  int errors;

  logic [31:0] words [4];

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  assign bus0.ce     = ce_v[0];
  assign bus0.we     = we_v[0];
  assign bus0.addr   = addr_v[0];
  assign bus0.dataIn = din_v[0];
  assign dout_v[0]   = bus0.dataOut;
  assign rdy_v[0]    = bus0.ready;
  assign err_v[0]    = bus0.err;
  assign busy_v[0]   = bus0.busy;

  assign bus1.ce     = ce_v[1];
  assign bus1.we     = we_v[1];
  assign bus1.addr   = addr_v[1];
  assign bus1.dataIn = din_v[1];
  assign dout_v[1]   = bus1.dataOut;
  assign rdy_v[1]    = bus1.ready;
  assign err_v[1]    = bus1.err;
  assign busy_v[1]   = bus1.busy;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2), .CNT_W(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int waitc(input int s);
    return (s == 1) ? 2 : 0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single access: ce held through the wait phase, inputs scrambled after accept
  task automatic access(input int s, input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_dout);
    int          lat;
    logic        got_err;
    logic [31:0] got_dout;
    ce_v[s]   = 1'b1;
    we_v[s]   = w;
    addr_v[s] = a;
    din_v[s]  = d;
    lat       = 0;
    got_err   = 1'b0;
    got_dout  = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check_eq({tag, "_busy"}, 32'(busy_v[s]), 32'd1);
        addr_v[s] = ~a;
        din_v[s]  = ~d;
        we_v[s]   = ~w;
      end
      if (i == waitc(s) + 1) ce_v[s] = 1'b0;
      if (rdy_v[s]) begin
        lat      = i - 1;
        got_err  = err_v[s];
        got_dout = dout_v[s];
        break;
      end
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(waitc(s) + 1));
    check_eq({tag, "_err"}, 32'(got_err), 32'(exp_err));
    check_eq({tag, "_dout"}, got_dout, exp_dout);
    @(negedge clk);
    check_eq({tag, "_rdy_off"}, 32'(rdy_v[s]), 32'd0);
  endtask

  // Four reads of 0x0..0xC with ce held high throughout
  task automatic b2b(input int s, input string tag);
    int seen;
    int last;
    seen      = 0;
    last      = 0;
    ce_v[s]   = 1'b1;
    we_v[s]   = 1'b0;
    addr_v[s] = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rdy_v[s]) begin
        if (seen < 4) check_eq({tag, "_data"}, dout_v[s], words[seen]);
        if (seen == 0) check_eq({tag, "_first"}, 32'(i), 32'(waitc(s) + 2));
        else check_eq({tag, "_gap"}, 32'(i - last), 32'(waitc(s) + 2));
        seen++;
        last = i;
        if (seen < 4) addr_v[s] = 32'(seen * 4);
        else ce_v[s] = 1'b0;
      end
    end
    check_eq({tag, "_count"}, 32'(seen), 32'd4);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    words[0]  = 32'h1111_0000;
    words[1]  = 32'h2222_0004;
    words[2]  = 32'h3333_0008;
    words[3]  = 32'h4444_000C;
    rst       = 1'b1;
    ce_v      = '0;
    we_v      = '0;
    addr_v[0] = '0;
    addr_v[1] = '0;
    din_v[0]  = '0;
    din_v[1]  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        check_eq("idle_flags", {29'd0, rdy_v[s], err_v[s], busy_v[s]}, 32'd0);
        check_eq("idle_dout", dout_v[s], 32'd0);
      end
    end

    // Basic write/read and setup on the two-wait responder
    access(1, "wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    access(1, "rd10", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++)
      access(1, "wrw", 1'b1, 32'(k * 4), words[k], 1'b0, 32'hDEAD_BEEF);
    access(1, "wr20", 1'b1, 32'h20, 32'h0BAD_F00D, 1'b0, 32'hDEAD_BEEF);
    access(1, "wr30", 1'b1, 32'h30, 32'h3030_3030, 1'b0, 32'hDEAD_BEEF);

    // Error responses
    access(1, "mis13", 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
    access(1, "rd10b", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
    access(1, "oor1000", 1'b1, 32'h1000, 32'hFFFF_FFFF, 1'b1, 32'h0);
    access(1, "rd0alias", 1'b0, 32'h0, 32'h0, 1'b0, 32'h1111_0000);

    // Abort during WAIT
    ce_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h20; din_v[1] = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check_eq("abort_busy", 32'(busy_v[1]), 32'd1);
    ce_v[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("abort_nordy", 32'(rdy_v[1]), 32'd0);
    end
    check_eq("abort_idle", 32'(busy_v[1]), 32'd0);
    check_eq("abort_dout", dout_v[1], 32'h1111_0000);
    access(1, "rd20", 1'b0, 32'h20, 32'h0, 1'b0, 32'h0BAD_F00D);

    // Back-to-back reads
    b2b(1, "b2b_w2");
    for (int k = 0; k < 4; k++)
      access(0, "wrw0", 1'b1, 32'(k * 4), words[k], 1'b0, 32'h0);
    access(0, "rd4_w0", 1'b0, 32'h4, 32'h0, 1'b0, 32'h2222_0004);
    b2b(0, "b2b_w0");

    // Reset in the middle of a write
    ce_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h30; din_v[1] = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    check_eq("rst_pre_busy", 32'(busy_v[1]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_busy", 32'(busy_v[1]), 32'd0);
    check_eq("rst_rdy_err", {30'd0, rdy_v[1], err_v[1]}, 32'd0);
    check_eq("rst_dout", dout_v[1], 32'd0);
    ce_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access(1, "rd30_kept", 1'b0, 32'h30, 32'h0, 1'b0, 32'h3030_3030);
    access(1, "rd10_kept", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
